// File: rtl/instruction_memory_ctrl.sv
// Instruction memory for the IF stage. Words are loaded through an
// auto-incrementing write pointer, fetched by byte PC, and zeroed by a clear engine.
module instruction_memory_ctrl #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  parameter int PC_BUS_SIZE        = 32
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_instruction_write,
  input  logic [WORD_SIZE_IN_BYTES*8-1:0]          i_instruction,
  input  logic                                     i_clear_mem,
  input  logic [PC_BUS_SIZE-1:0]                   i_pc,
  output logic [WORD_SIZE_IN_BYTES*8-1:0]          o_instruction,
  output logic                                     o_addr_error,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]   o_word_count,
  output logic                                     o_full,
  output logic                                     o_empty,
  output logic                                     o_overflow,
  output logic                                     o_clearing
);

  // state    | meaning
  // IDLE     | loader and fetch active; i_clear_mem starts a clear
  // CLEARING | one word zeroed per cycle; writes and clear requests ignored

  localparam int DATA_W = WORD_SIZE_IN_BYTES * 8;
  localparam int OFF_W  = $clog2(WORD_SIZE_IN_BYTES);
  localparam int PTR_W  = (MEM_SIZE_IN_WORDS > 1) ? $clog2(MEM_SIZE_IN_WORDS) : 1;
  localparam int CNT_W  = $clog2(MEM_SIZE_IN_WORDS + 1);

  localparam logic [PTR_W-1:0]       LAST_IDX = PTR_W'(MEM_SIZE_IN_WORDS - 1);
  localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(MEM_SIZE_IN_WORDS);
  localparam logic [PC_BUS_SIZE-1:0] OFF_MASK = PC_BUS_SIZE'(WORD_SIZE_IN_BYTES - 1);
  localparam logic [PC_BUS_SIZE-1:0] DEPTH_PC = PC_BUS_SIZE'(MEM_SIZE_IN_WORDS);

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] clr_idx_q, clr_idx_d;
  logic             ovf_q, ovf_d;

  logic [DATA_W-1:0] mem [MEM_SIZE_IN_WORDS];

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [PC_BUS_SIZE-1:0] pc_idx;
  logic [PTR_W-1:0]       rd_idx;
  logic                   addr_err;
  logic                   full;

  // Range check uses the whole shifted PC so high bits can never alias into the array.
  assign pc_idx   = i_pc >> OFF_W;
  assign rd_idx   = pc_idx[PTR_W-1:0];
  assign addr_err = ((i_pc & OFF_MASK) != '0) || (pc_idx >= DEPTH_PC);
  assign full     = (cnt_q == FULL_CNT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      clr_idx_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      clr_idx_q <= clr_idx_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    clr_idx_d = clr_idx_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = i_instruction;

    unique case (state_q)
      IDLE: begin
        if (i_clear_mem) begin
          state_d   = CLEARING;
          clr_idx_d = '0;
        end else if (i_instruction_write) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d    = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      CLEARING: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          wr_ptr_d  = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + PTR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Array has no reset; contents survive reset and are only zeroed by a clear.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_instruction <= '0;
      o_addr_error  <= 1'b0;
    end else if (addr_err) begin
      o_instruction <= '0;
      o_addr_error  <= 1'b1;
    end else if (state_q == CLEARING) begin
      o_instruction <= '0;
      o_addr_error  <= 1'b0;
    end else begin
      o_instruction <= mem[rd_idx];
      o_addr_error  <= 1'b0;
    end
  end

  assign o_word_count = cnt_q;
  assign o_full       = full;
  assign o_empty      = (cnt_q == '0);
  assign o_overflow   = ovf_q;
  assign o_clearing   = (state_q == CLEARING);

endmodule
